shift_reg_param: RTL and testbench

SHIFT_REG_PARAM -- requirements
Module: shift_reg_param

---
 rtl/shift_reg_param.sv | 131 +++++++++++++
 tb/tb_shift_reg_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_reg_param                                                 |
// | Purpose  : Parameterised bidirectional shift register. It supports forward |
// |            and backward shifts, rotate, parallel load and a stage-select   |
// |            tap. A saturating fill counter tracks how many stages have been |
// |            written since reset.                                            |
// | Ports    : clk, rst      - clock, synchronous active-high reset            |
// |            en            - stage-update enable (0 holds everything)        |
// |            mode[1:0]     - 00 hold, 01 fwd shift, 10 bwd shift, 11 load    |
// |            rot           - rotate instead of taking serial input           |
// |            din_fwd/bwd   - serial inputs for forward/backward shifts       |
// |            pdata         - parallel load data, stage i at [i*WIDTH+:WIDTH] |
// |            tap_sel       - stage index driven onto q_tap                   |
// |            q_fwd/q_bwd   - last stage / first stage                        |
// |            q_tap, pq     - selected stage / all stages packed              |
// |            fill, full    - stages written (saturating), fill == DEPTH      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module shift_reg_param #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 3,
  localparam int SW    = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic                   rot,
  input  logic [WIDTH-1:0]       din_fwd,
  input  logic [WIDTH-1:0]       din_bwd,
  input  logic [WIDTH*DEPTH-1:0] pdata,
  input  logic [SW-1:0]          tap_sel,
  output logic [WIDTH-1:0]       q_fwd,
  output logic [WIDTH-1:0]       q_bwd,
  output logic [WIDTH-1:0]       q_tap,
  output logic [WIDTH*DEPTH-1:0] pq,
  output logic [CW-1:0]          fill,
  output logic                   full
);

  localparam logic [1:0]    c_mode_hold = 2'b00;
  localparam logic [1:0]    c_mode_fwd  = 2'b01;
  localparam logic [1:0]    c_mode_bwd  = 2'b10;
  localparam logic [1:0]    c_mode_load = 2'b11;
  localparam logic [CW-1:0] c_fill_max  = CW'(DEPTH);
  // Tap lookup is padded to a power of two so every tap_sel value has an entry.
  localparam int            c_ntap      = 2 ** SW;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [CW-1:0]    fill_q;
  logic [CW-1:0]    fill_d;
  logic [WIDTH-1:0] tap_arr [c_ntap];

  // Next-state logic for stages and fill counter.
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (en) begin
      case (mode)
        c_mode_hold: begin
        end
        c_mode_fwd: begin
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
          end
          stage_d[0] = rot ? stage_q[DEPTH-1] : din_fwd;
          // A rotate only rearranges existing data, so it does not count as a write.
          if (!rot && (fill_q != c_fill_max)) begin
            fill_d = fill_q + CW'(1);
          end
        end
        c_mode_bwd: begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            stage_d[i] = stage_q[i+1];
          end
          stage_d[DEPTH-1] = rot ? stage_q[0] : din_bwd;
          if (!rot && (fill_q != c_fill_max)) begin
            fill_d = fill_q + CW'(1);
          end
        end
        c_mode_load: begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = pdata[i*WIDTH +: WIDTH];
          end
          fill_d = c_fill_max;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      fill_q <= '0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
    end
  end

  // Out-of-range tap indices (possible when DEPTH is not a power of two) read 0.
  always_comb begin
    for (int i = 0; i < c_ntap; i++) begin
      tap_arr[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      tap_arr[i] = stage_q[i];
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
      assign pq[g*WIDTH +: WIDTH] = stage_q[g];
    end
  endgenerate

  assign q_fwd = stage_q[DEPTH-1];
  assign q_bwd = stage_q[0];
  assign q_tap = tap_arr[tap_sel];
  assign fill  = fill_q;
  assign full  = (fill_q == c_fill_max);

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_shift_reg_param                                              |
// | Purpose  : Self-checking bench for shift_reg_param. It drives a DEPTH=4    |
// |            and a DEPTH=3 instance (WIDTH=8) from shared controls. Each     |
// |            edge is compared against a queue-based reference model, and     |
// |            directed vector-table and corner-case sequences are also run.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_shift_reg_param;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        rot;
    logic [7:0]  df;
    logic [7:0]  db;
    logic [31:0] pd;
    logic [1:0]  tap;
    logic [31:0] epq;
    int          efill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en, rot;
  logic [1:0]  mode;
  logic [7:0]  din_fwd, din_bwd;
  logic [31:0] pdata;
  logic [1:0]  tap0, tap1;

  logic [7:0]  d0_qf, d0_qb, d0_qt;
  logic [31:0] d0_pq;
  logic [2:0]  d0_fill;
  logic        d0_full;
  logic [7:0]  d1_qf, d1_qb, d1_qt;
  logic [23:0] d1_pq;
  logic [1:0]  d1_fill;
  logic        d1_full;

  int errors = 0;
  int checks = 0;

  bq_t q0, q1;
  int  f0, f1;

  always #5 clk = ~clk;

  shift_reg_param #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
    .din_fwd(din_fwd), .din_bwd(din_bwd), .pdata(pdata), .tap_sel(tap0),
    .q_fwd(d0_qf), .q_bwd(d0_qb), .q_tap(d0_qt), .pq(d0_pq),
    .fill(d0_fill), .full(d0_full)
  );

  shift_reg_param #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
    .din_fwd(din_fwd), .din_bwd(din_bwd), .pdata(pdata[23:0]), .tap_sel(tap1),
    .q_fwd(d1_qf), .q_bwd(d1_qb), .q_tap(d1_qt), .pq(d1_pq),
    .fill(d1_fill), .full(d1_full)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Queue model: index 0 is stage 0. A forward shift pushes at the front;
  // a backward shift pushes at the back.
  function automatic bq_t model_next(input bq_t q, input logic [1:0] md, input logic r,
                                     input logic [7:0] df, input logic [7:0] db,
                                     input logic [31:0] pd, input int d);
    bq_t n = q;
    case (md)
      2'b01: begin
        n.push_front(r ? q[d-1] : df);
        void'(n.pop_back());
      end
      2'b10: begin
        n.push_back(r ? q[0] : db);
        void'(n.pop_front());
      end
      2'b11: begin
        n.delete();
        for (int i = 0; i < d; i++) n.push_back(pd[i*8 +: 8]);
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic int fill_next(input int f, input logic [1:0] md, input logic r, input int d);
    if (md == 2'b11) return d;
    if ((md == 2'b01 || md == 2'b10) && !r) return (f + 1 > d) ? d : f + 1;
    return f;
  endfunction

  function automatic bq_t zeros(input int d);
    bq_t z;
    for (int i = 0; i < d; i++) z.push_back(8'h00);
    return z;
  endfunction

  function automatic logic [31:0] pack(input bq_t q);
    logic [31:0] r = '0;
    foreach (q[i]) r[i*8 +: 8] = q[i];
    return r;
  endfunction

  function automatic logic [7:0] tap_of(input bq_t q, input int t);
    return (t < q.size()) ? q[t] : 8'h00;
  endfunction

  // One clock edge: advance the model with the inputs sampled at the edge,
  // then compare both instances against it just after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      q0 = zeros(4); f0 = 0;
      q1 = zeros(3); f1 = 0;
    end else if (en) begin
      q0 = model_next(q0, mode, rot, din_fwd, din_bwd, pdata, 4);
      f0 = fill_next(f0, mode, rot, 4);
      q1 = model_next(q1, mode, rot, din_fwd, din_bwd, pdata, 3);
      f1 = fill_next(f1, mode, rot, 3);
    end
    #1;
    chk("d4_pq",    d0_pq,            pack(q0));
    chk("d4_fill",  32'(d0_fill),     32'(f0));
    chk("d4_full",  32'(d0_full),     32'(f0 == 4));
    chk("d4_qfwd",  32'(d0_qf),       32'(q0[3]));
    chk("d4_qbwd",  32'(d0_qb),       32'(q0[0]));
    chk("d4_qtap",  32'(d0_qt),       32'(tap_of(q0, int'(tap0))));
    chk("d3_pq",    {8'h00, d1_pq},   pack(q1));
    chk("d3_fill",  32'(d1_fill),     32'(f1));
    chk("d3_full",  32'(d1_full),     32'(f1 == 3));
    chk("d3_qfwd",  32'(d1_qf),       32'(q1[2]));
    chk("d3_qbwd",  32'(d1_qb),       32'(q1[0]));
    chk("d3_qtap",  32'(d1_qt),       32'(tap_of(q1, int'(tap1))));
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; rot = 1'b0;
    din_fwd = '0; din_bwd = '0; pdata = '0; tap0 = '0; tap1 = '0;
    q0 = zeros(4); q1 = zeros(3); f0 = 0; f1 = 0;

    // Directed vectors for the DEPTH=4 instance; expected values after the edge.
    tbl.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 32'h0,        2'd0, 32'h00000000, 0});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 8'hA1, 8'h00, 32'h0,        2'd0, 32'h000000A1, 1});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 8'hB2, 8'h00, 32'h0,        2'd1, 32'h0000A1B2, 2});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 8'hC3, 8'h00, 32'h0,        2'd2, 32'h00A1B2C3, 3});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 8'hD4, 8'h00, 32'h0,        2'd3, 32'hA1B2C3D4, 4});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b1, 8'h00, 8'hEE, 32'h0,        2'd0, 32'hD4A1B2C3, 4});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 1'b1, 8'hEE, 8'h00, 32'h0,        2'd1, 32'hA1B2C3D4, 4});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 1'b0, 8'hFF, 8'hFF, 32'h0,        2'd0, 32'hA1B2C3D4, 4});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 1'b0, 8'hFF, 8'hFF, 32'h0,        2'd0, 32'hA1B2C3D4, 4});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 1'b0, 8'hFF, 8'hFF, 32'h0,        2'd0, 32'hA1B2C3D4, 4});
    tbl.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 8'hFF, 8'hFF, 32'h0,        2'd0, 32'hA1B2C3D4, 4});
    tbl.push_back('{1'b1, 1'b1, 2'b01, 1'b0, 8'h12, 8'h00, 32'h0,        2'd0, 32'h00000000, 0});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 1'b1, 8'h00, 8'h00, 32'h11223344, 2'd2, 32'h11223344, 4});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 32'h0,        2'd0, 32'h00000000, 0});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 8'h05, 8'h00, 32'h0,        2'd0, 32'h00000005, 1});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 8'h06, 8'h00, 32'h0,        2'd1, 32'h00000506, 2});
    tbl.push_back('{1'b1, 1'b1, 2'b11, 1'b0, 8'h00, 8'h00, 32'hDEADBEEF, 2'd0, 32'h00000000, 0});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 8'h5A, 8'h00, 32'h0,        2'd0, 32'h0000005A, 1});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 8'h77, 32'h0,        2'd3, 32'h77000000, 2});

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode; rot = tbl[i].rot;
      din_fwd = tbl[i].df; din_bwd = tbl[i].db; pdata = tbl[i].pd;
      tap0 = tbl[i].tap; tap1 = tbl[i].tap;
      tick();
      chk("vec_pq",   d0_pq,        tbl[i].epq);
      chk("vec_fill", 32'(d0_fill), 32'(tbl[i].efill));
      chk("vec_full", 32'(d0_full), 32'(tbl[i].efill == 4));
      chk("vec_qfwd", 32'(d0_qf),   32'(tbl[i].epq[31:24]));
      chk("vec_qbwd", 32'(d0_qb),   32'(tbl[i].epq[7:0]));
      chk("vec_qtap", 32'(d0_qt),   32'(tbl[i].epq[tbl[i].tap*8 +: 8]));
    end

    // Latency and saturation: reset, then six forward writes.
    rst = 1'b1; en = 1'b0; mode = 2'b00; rot = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1; mode = 2'b01; tap1 = 2'd3;
    for (int k = 0; k < 6; k++) begin
      din_fwd = 8'(8'h30 + k);
      tick();
      chk("sat_d3_fill", 32'(d1_fill), 32'((k + 1 > 3) ? 3 : k + 1));
      chk("d3_tap3_zero", 32'(d1_qt), 32'h0);
      // The value written at edge k reaches q_fwd after DEPTH-1 more edges.
      if (k >= 3) chk("lat_d4_qfwd", 32'(d0_qf), 32'(8'h30 + k - 3));
      else        chk("lat_d4_qfwd", 32'(d0_qf), 32'h0);
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 24) == 0);
      en      = ($urandom_range(0, 4) != 0);
      mode    = 2'($urandom_range(0, 3));
      rot     = ($urandom_range(0, 3) == 0);
      din_fwd = 8'($urandom);
      din_bwd = 8'($urandom);
      pdata   = $urandom;
      tap0    = 2'($urandom_range(0, 3));
      tap1    = 2'($urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
